// File: rtl/led_pattern_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : led_pattern_pkg
// Description : Shared display-mode encoding and counter sizing helper for
//               the LED pattern controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package led_pattern_pkg;

   // Display mode, taken from the two top switch bits
   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_DIM   = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_CHASE = 2'b11
   } mode_e;

   // Bits needed for a counter running 0..MAX_VAL-1 (never less than one bit)
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_ctrl_sw_debounce.sv
//------------------------------------------------------------------------------
// Module      : sw_debounce
// Description : Two-flop synchroniser plus tick-based debouncer for the DIP
//               switch bank. A value is accepted once it has been seen
//               unchanged on DEB_TICKS consecutive ticks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sw_debounce
   import led_pattern_pkg::*;
#(
   parameter int SW_W      = 4,
   parameter int DEB_TICKS = 20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            tick_i,
   input  logic [SW_W-1:0] sw_i,
   output logic [SW_W-1:0] sw_o
);

   // Counter must hold 0..DEB_TICKS inclusive
   localparam int CNT_W = cnt_width(DEB_TICKS + 1);

   logic [SW_W-1:0]  sync1_q, sync2_q;
   logic [SW_W-1:0]  cand_q,  cand_d;
   logic [SW_W-1:0]  deb_q,   deb_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // Bring the asynchronous switches into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
      end
   end

   // Candidate tracking and acceptance; the debounced value follows the
   // candidate one cycle after the stability count saturates
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      deb_d  = deb_q;
      if (cnt_q == CNT_W'(DEB_TICKS)) begin
         deb_d = cand_q;
      end
      if (tick_i) begin
         if (sync2_q == cand_q) begin
            if (cnt_q != CNT_W'(DEB_TICKS)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            cand_d = sync2_q;
            cnt_d  = '0;
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cand_q <= '0;
         cnt_q  <= '0;
         deb_q  <= '0;
      end else begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign sw_o = deb_q;

endmodule

`default_nettype wire

// File: rtl/led_pattern_ctrl.sv
//------------------------------------------------------------------------------
// Module      : led_pattern_ctrl
// Description : Drives N_LEDS LEDs from a debounced DIP-switch bank with four
//               timed display modes: off, PWM dim, blink and chase.
//               Optional macro LED_CHASE_BOUNCE_EN makes the chase ping-pong
//               instead of wrapping around.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_pattern_ctrl
   import led_pattern_pkg::*;
#(
   parameter int N_LEDS      = 3,
   parameter int SW_W        = 4,
   parameter int TICK_DIV    = 24000,
   parameter int DEB_TICKS   = 20,
   parameter int BLINK_TICKS = 250,
   parameter int STEP_TICKS  = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [SW_W-1:0]   sw,
   output logic [N_LEDS-1:0] led,
   output logic [1:0]        mode,
   output logic              tick
);

   localparam int LVL_W     = SW_W - 2;
   localparam int LVL_N     = 1 << LVL_W;
   localparam int PRE_W     = cnt_width(TICK_DIV);
   localparam int BLINK_MAX = BLINK_TICKS * LVL_N;
   localparam int STEP_MAX  = STEP_TICKS * LVL_N;
   localparam int BLK_W     = cnt_width(BLINK_MAX);
   localparam int STP_W     = cnt_width(STEP_MAX);

   logic [PRE_W-1:0]  pre_q,       pre_d;
   logic [LVL_W-1:0]  p_q,         p_d;
   mode_e             prev_mode_q;
   logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              phase_q,     phase_d;
   logic [STP_W-1:0]  step_cnt_q,  step_cnt_d;
   logic [N_LEDS-1:0] pos_q,       pos_d;
   logic [N_LEDS-1:0] led_q,       led_d;
`ifdef LED_CHASE_BOUNCE_EN
   logic              dir_up_q,    dir_up_d;
`endif

   logic [SW_W-1:0]   sw_deb;
   mode_e             cur_mode;
   logic [LVL_W-1:0]  level;
   logic              mode_chg;
   logic              pwm_on;
   logic [BLK_W-1:0]  blink_last;
   logic [STP_W-1:0]  step_last;

   sw_debounce #(
      .SW_W      (SW_W),
      .DEB_TICKS (DEB_TICKS)
   ) u_sw_debounce (
      .clk    (clk),
      .reset  (reset),
      .tick_i (tick),
      .sw_i   (sw),
      .sw_o   (sw_deb)
   );

   assign tick       = (pre_q == PRE_W'(TICK_DIV - 1));
   assign cur_mode   = mode_e'(sw_deb[SW_W-1 -: 2]);
   assign level      = sw_deb[LVL_W-1:0];
   assign mode       = sw_deb[SW_W-1 -: 2];
   assign mode_chg   = (cur_mode != prev_mode_q);
   assign pwm_on     = (&level) || (p_q < level);
   // Terminal counts; compared with >= so a lowered level takes effect at once
   assign blink_last = BLK_W'(BLINK_TICKS * (int'(level) + 1) - 1);
   assign step_last  = STP_W'(STEP_TICKS * (int'(level) + 1) - 1);

   // Timebase prescaler and free-running PWM ramp
   always_comb begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      p_d   = p_q + LVL_W'(1);
   end

   // Pattern sequencing: a mode change restarts the pattern, level alone does not
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      step_cnt_d  = step_cnt_q;
      pos_d       = pos_q;
`ifdef LED_CHASE_BOUNCE_EN
      dir_up_d    = dir_up_q;
`endif
      if (mode_chg) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
         step_cnt_d  = '0;
         pos_d       = N_LEDS'(1);
`ifdef LED_CHASE_BOUNCE_EN
         dir_up_d    = 1'b1;
`endif
      end else if (tick) begin
         case (cur_mode)
            MODE_BLINK: begin
               if (blink_cnt_q >= blink_last) begin
                  blink_cnt_d = '0;
                  phase_d     = ~phase_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + BLK_W'(1);
               end
            end
            MODE_CHASE: begin
               if (step_cnt_q >= step_last) begin
                  step_cnt_d = '0;
`ifdef LED_CHASE_BOUNCE_EN
                  if (dir_up_q) begin
                     if (pos_q[N_LEDS-1]) begin
                        dir_up_d = 1'b0;
                        pos_d    = pos_q >> 1;
                     end else begin
                        pos_d    = pos_q << 1;
                     end
                  end else begin
                     if (pos_q[0]) begin
                        dir_up_d = 1'b1;
                        pos_d    = pos_q << 1;
                     end else begin
                        pos_d    = pos_q >> 1;
                     end
                  end
`else
                  pos_d = {pos_q[N_LEDS-2:0], pos_q[N_LEDS-1]};
`endif
               end else begin
                  step_cnt_d = step_cnt_q + STP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // LED image built from the state being loaded this cycle
   always_comb begin
      led_d = '0;
      case (cur_mode)
         MODE_DIM:   led_d = {N_LEDS{pwm_on}};
         MODE_BLINK: led_d = {N_LEDS{phase_d}};
         MODE_CHASE: led_d = pos_d;
         default:    led_d = '0;
      endcase
   end

   // All controller state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q       <= '0;
         p_q         <= '0;
         prev_mode_q <= MODE_OFF;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         step_cnt_q  <= '0;
         pos_q       <= N_LEDS'(1);
         led_q       <= '0;
`ifdef LED_CHASE_BOUNCE_EN
         dir_up_q    <= 1'b1;
`endif
      end else begin
         pre_q       <= pre_d;
         p_q         <= p_d;
         prev_mode_q <= cur_mode;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         step_cnt_q  <= step_cnt_d;
         pos_q       <= pos_d;
         led_q       <= led_d;
`ifdef LED_CHASE_BOUNCE_EN
         dir_up_q    <= dir_up_d;
`endif
      end
   end

   assign led = led_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_led_pattern_ctrl
// Description : Directed self-checking bench for led_pattern_ctrl with a fast
//               timebase (TICK_DIV=4, DEB_TICKS=2, BLINK_TICKS=3, STEP_TICKS=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_pattern_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] sw;
   logic [2:0] led;
   logic [1:0] mode;
   logic       tick;

   int errors = 0;
   int checks = 0;
   int oh_bad = 0;

   led_pattern_ctrl #(
      .N_LEDS      (3),
      .SW_W        (4),
      .TICK_DIV    (4),
      .DEB_TICKS   (2),
      .BLINK_TICKS (3),
      .STEP_TICKS  (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sw    (sw),
      .led   (led),
      .mode  (mode),
      .tick  (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for led to change; optionally count non-one-hot samples
   task automatic wait_chg(input string tag, input int maxc, input bit oh,
                           output int cyc, output logic [2:0] val);
      logic [2:0] prev;
      prev = led;
      cyc  = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (oh && !$onehot(led)) oh_bad++;
      end while (led === prev && cyc < maxc);
      val = led;
      chk({tag, "_changed"}, 32'(led !== prev), 32'd1);
   endtask

   initial begin
      int         cyc;
      int         cnt;
      int         first_tick;
      logic [2:0] val;

      // ---- reset held ----
      reset = 1'b0;
      sw    = 4'b1111;
      repeat (3) @(negedge clk);
      chk("rst_led",  32'(led),  32'd0);
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);

      // ---- release: tick cadence and acceptance latency ----
      reset      = 1'b1;
      cnt        = 0;
      first_tick = 0;
      cyc        = 0;
      repeat (12) begin
         @(negedge clk);
         cyc++;
         if (tick) begin
            cnt++;
            if (first_tick == 0) first_tick = cyc;
         end
      end
      chk("tick_first", 32'(first_tick), 32'd3);
      chk("tick_count", 32'(cnt),        32'd3);
      while (mode != 2'b11 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk("accept_latency", 32'(cyc), 32'd13);
      @(negedge clk);
      chk("chase_start", 32'(led), 32'b001);

      // ---- DIM ----
      sw  = 4'b0100;
      cyc = 0;
      while (mode != 2'b01 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk("dim_mode", 32'(mode), 32'd1);
      @(negedge clk);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (led != 3'b000) cnt++;
      end
      chk("dim_lvl0_dark", 32'(cnt), 32'd0);

      sw = 4'b0111;
      repeat (20) @(negedge clk);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (led == 3'b111) cnt++;
      end
      chk("dim_lvl3_solid", 32'(cnt), 32'd8);

      sw = 4'b0110;
      repeat (20) @(negedge clk);
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (led == 3'b111) cnt++;
      end
      chk("dim_lvl2_per4", 32'(cnt), 32'd2);
      cnt = 0;
      repeat (16) begin
         @(negedge clk);
         if (led == 3'b111) cnt++;
         else if (led != 3'b000) cnt += 100;
      end
      chk("dim_lvl2_per16", 32'(cnt), 32'd8);

      // ---- BLINK ----
      sw  = 4'b1000;
      cyc = 0;
      while (mode != 2'b10 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      chk("blink_mode", 32'(mode), 32'd2);
      @(negedge clk);
      chk("blink_on_at_accept", 32'(led), 32'b111);
      wait_chg("blink_t1", 20, 1'b0, cyc, val);
      chk("blink_t1_val", 32'(val), 32'b000);
      wait_chg("blink_t2", 20, 1'b0, cyc, val);
      chk("blink_t2_val", 32'(val), 32'b111);
      chk("blink_t2_cyc", 32'(cyc), 32'd12);

      // level change straight after an ON toggle; phase must not restart
      sw = 4'b1001;
      wait_chg("blink_t3", 20, 1'b0, cyc, val);
      chk("blink_t3_val", 32'(val), 32'b000);
      chk("blink_t3_cyc", 32'(cyc), 32'd12);
      wait_chg("blink_t4", 40, 1'b0, cyc, val);
      chk("blink_t4_val", 32'(val), 32'b111);
      chk("blink_t4_cyc", 32'(cyc), 32'd24);

      // ---- CHASE ----
      sw = 4'b1100;
      wait_chg("chase_s0", 30, 1'b0, cyc, val);
      chk("chase_s0_val", 32'(val), 32'b001);
      chk("chase_s0_cyc", 32'(cyc), 32'd14);
      wait_chg("chase_s1", 20, 1'b1, cyc, val);
      chk("chase_s1_val", 32'(val), 32'b010);
      chk("chase_s1_cyc", 32'(cyc), 32'd6);
      wait_chg("chase_s2", 20, 1'b1, cyc, val);
      chk("chase_s2_val", 32'(val), 32'b100);
      chk("chase_s2_cyc", 32'(cyc), 32'd8);
      wait_chg("chase_s3", 20, 1'b1, cyc, val);
`ifdef LED_CHASE_BOUNCE_EN
      chk("chase_s3_val", 32'(val), 32'b010);
`else
      chk("chase_s3_val", 32'(val), 32'b001);
`endif
      chk("chase_s3_cyc", 32'(cyc), 32'd8);

      // ---- glitch: one tick of BLINK, then back ----
      sw = 4'b1000;
      repeat (4) begin
         @(negedge clk);
         if (!$onehot(led)) oh_bad++;
      end
      sw = 4'b1100;
      wait_chg("glitch_s1", 20, 1'b1, cyc, val);
`ifdef LED_CHASE_BOUNCE_EN
      chk("glitch_s1_val", 32'(val), 32'b001);
`else
      chk("glitch_s1_val", 32'(val), 32'b010);
`endif
      chk("glitch_s1_cyc", 32'(cyc), 32'd4);
      chk("glitch_mode",   32'(mode), 32'd3);
`ifdef LED_CHASE_BOUNCE_EN
      wait_chg("glitch_s2", 20, 1'b1, cyc, val);
      chk("glitch_s2_val", 32'(val), 32'b010);
      chk("glitch_s2_cyc", 32'(cyc), 32'd8);
`endif
      chk("chase_onehot", 32'(oh_bad), 32'd0);

      // ---- asynchronous reset mid-chase at 010 ----
      #1 reset = 1'b0;
      #1;
      chk("midrst_led",  32'(led),  32'd0);
      chk("midrst_mode", 32'(mode), 32'd0);
      chk("midrst_tick", 32'(tick), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_chg("restart_s0", 30, 1'b0, cyc, val);
      chk("restart_s0_val", 32'(val), 32'b001);
      chk("restart_s0_cyc", 32'(cyc), 32'd14);
      wait_chg("restart_s1", 20, 1'b0, cyc, val);
      chk("restart_s1_val", 32'(val), 32'b010);
      chk("restart_s1_cyc", 32'(cyc), 32'd6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Parametrised successor to the on-board LED controller: drives N_LEDS board LEDs from a DIP-switch bank.
- Adds synchronisation, debouncing and four timed display modes: off, PWM dim, blink, chase.
- Sits between the board switch pins and the LED pins at top level; a single clk domain (HSOSC-derived).

Parameters:
- N_LEDS, 3, number of LED outputs (>=2).
- SW_W, 4, switch bank width (>=3); sw[SW_W-1:SW_W-2] = mode, sw[SW_W-3:0] = level (LVL_W = SW_W-2).
- TICK_DIV, 24000, clk cycles per timebase tick (>=2).
- DEB_TICKS, 20, ticks a synchronised switch value must be stable before acceptance.
- BLINK_TICKS, 250, base half-period of blink, in ticks.
- STEP_TICKS, 100, base chase step time, in ticks.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sw  in  SW_W  raw DIP switches, asynchronous to clk.
- led  out  N_LEDS  LED drive, 1 = lit.
- mode  out  2  currently accepted mode (debounced).
- tick  out  1  one-cycle timebase strobe, for observability.

Behaviour:
- Reset (reset=0, asynchronous): led=0, mode=00, tick=0. Synchroniser, debounced switch register, and all counters are cleared.
- Synchroniser: 2-flop on sw.
- Tick: prescaler counts 0..TICK_DIV-1. tick=1 for the single cycle when count == TICK_DIV-1, then wraps to 0.
- Debounce:
  - On each tick, if the synced value equals the candidate, the stability counter increments (saturating at DEB_TICKS); otherwise the candidate is loaded and the counter is cleared.
  - When the counter reaches DEB_TICKS, the debounced register loads the candidate.
  - Latency from a stable sw change to mode/led update: 2 cycles + between DEB_TICKS and DEB_TICKS+1 ticks, + 1 cycle.
- Mode change (debounced mode differs from the previous cycle): on the same cycle, the blink counter and chase counter are cleared, blink phase is set to ON, and the chase position is set to led[0]. A level change alone does not restart the pattern.
- PWM: free-running LVL_W-bit counter p, incremented every clk. pwm_on = (level == all-ones) || (p < level).
- Mode 00 OFF: led = 0.
- Mode 01 DIM: led = {N_LEDS{pwm_on}}. Level 0 = dark; level max = solid on.
- Mode 10 BLINK:
  - led = {N_LEDS{phase}}.
  - phase toggles after BLINK_TICKS*(level+1) ticks; the counter counts ticks, then wraps to 0 on toggle.
- Mode 11 CHASE:
  - One-hot position; advances every STEP_TICKS*(level+1) ticks.
  - Shifts led[i] -> led[i+1]; led[N_LEDS-1] wraps to led[0].
  - Output is exactly one-hot at all times.
- All multiplications are constant-bounded; counter widths come from $clog2 of the maximum product.
- led is registered: one cycle after the internal state.
- Reset mid-pattern: immediate return to the reset values; after release, the pattern restarts from the mode-change initial state once switches are re-accepted.

Optional Feature:
- Macro: LED_CHASE_BOUNCE_EN.
- Defined: CHASE ping-pongs. The position moves up to led[N_LEDS-1], then reverses down to led[0]; a direction flop resets to "up" on reset and on mode change.
- Undefined: wrap-around chase as above; no direction flop.

Decomposition:
- Package led_pattern_pkg:
  - typedef enum logic [1:0] {MODE_OFF, MODE_DIM, MODE_BLINK, MODE_CHASE}.
  - Helper function for counter width.
- One sub-module, sw_debounce (parametrised SW_W, DEB_TICKS, with tick input): contains the synchroniser and debounce. Instantiated once.

Test Plan (TICK_DIV=4, DEB_TICKS=2, BLINK_TICKS=3, STEP_TICKS=2, N_LEDS=3, SW_W=4):
- Reset held, sw=4'b1111 -> led=000, mode=00, tick=0. Release -> tick pulses every 4 cycles; mode=11 within 2+(2..3)*4+1 cycles.
- sw=4'b0100 (DIM, level 0) -> led=000 always. sw=4'b0111 -> led=111 steady. sw=4'b0110 -> led=111 for exactly 2 of every 4 cycles.
- sw=4'b1000 (BLINK, level 0) -> led=111 immediately on acceptance, toggles every 3 ticks (12 cycles). sw=4'b1001 -> toggles every 6 ticks, with no phase restart.
- sw=4'b1100 (CHASE) -> 001, 010, 100, 001 every 2 ticks; one-hot checked every cycle. With LED_CHASE_BOUNCE_EN: 001, 010, 100, 010, 001.
- Glitch: sw toggled to 4'b1000 for 1 tick, then back to 4'b1100 -> mode stays 11, chase not restarted.
- Assert reset mid-CHASE at position 010 -> led=000 asynchronously (same timestep). After release with sw unchanged, chase restarts at 001.
